mul_trap_ctrl: RTL and testbench

MUL_TRAP_CTRL -- requirements
Module: mul_trap_ctrl

---
 rtl/mul_trap_pkg.sv | 43 ++++
 rtl/trap_timeout_ctr.sv | 42 ++++
 rtl/mul_trap_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mul_trap_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_trap_pkg.sv
// rtl/mul_trap_pkg.sv - opcode, state and default constants for the MUL trap controller
//
// Shared by mul_trap_ctrl and its timeout counter. Holds:
//   - the four MUL-class opcodes decoded from if_instruction[31:25]
//   - the controller state encoding (IDLE, ARM, RUN, DRAIN, FLAGS, FAULT)
//   - default values for the controller parameters
//   - small opcode classification helpers
package mul_trap_pkg;

  localparam logic [6:0] OP_MULI  = 7'b0010000;
  localparam logic [6:0] OP_MULSI = 7'b0011000;
  localparam logic [6:0] OP_MUL   = 7'b0110000;
  localparam logic [6:0] OP_MULS  = 7'b0111000;

  localparam logic [15:0] DEF_UC_END_PC    = 16'd124;
  localparam int          DEF_TIMEOUT      = 1024;
  localparam int          DEF_DRAIN_CYCLES = 2;

  // State encoding kept as plain constants so existing decode tables
  // that match on raw state values continue to line up.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ARM   = 3'd1;
  localparam state_t ST_RUN   = 3'd2;
  localparam state_t ST_DRAIN = 3'd3;
  localparam state_t ST_FLAGS = 3'd4;
  localparam state_t ST_FAULT = 3'd5;

  function automatic logic is_mul_op(input logic [6:0] op);
    return (op == OP_MULI) || (op == OP_MULSI) || (op == OP_MUL) || (op == OP_MULS);
  endfunction

  // Immediate forms take their second operand from instruction bits [15:0].
  function automatic logic is_imm_form(input logic [6:0] op);
    return (op == OP_MULI) || (op == OP_MULSI);
  endfunction

  // Only the flag-setting forms produce a flag write at the end of the trap.
  function automatic logic is_flag_form(input logic [6:0] op);
    return (op == OP_MULS) || (op == OP_MULSI);
  endfunction

endpackage

// File: rtl/trap_timeout_ctr.sv
// rtl/trap_timeout_ctr.sv - saturating RUN-cycle counter for the MUL trap watchdog
//
// Counts enabled cycles since the last clear. expired is high during the
// LIMIT-th enabled cycle, so the owner sees it on the edge that completes
// LIMIT cycles of RUN. The count saturates there.
//
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-low reset
//   clear   in  zero the count (takes priority over enable)
//   enable  in  advance the count this cycle
//   expired out LIMIT enabled cycles reached with this one
module trap_timeout_ctr
  import mul_trap_pkg::*;
#(
  parameter int LIMIT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/mul_trap_ctrl.sv
// rtl/mul_trap_ctrl.sv - MUL-class instruction trap controller for the microcode sequencer
//
// Watches the fetch stream for MUL-class opcodes. On a valid MUL in IDLE it
// captures the instruction and precomputes the Z/N flags, freezes the main
// pipeline and hands control to the microcode sequencer until the sequencer
// PC reaches UC_END_PC. After a fixed drain period the flag-setting forms
// emit a one-cycle flag write. A sequence that overruns TIMEOUT RUN cycles
// parks in FAULT until reset.
//
// Ports:
//   clk               in   clock, rising edge
//   rst               in   synchronous active-low reset
//   if_instruction    in   [31:0] instruction from fetch
//   if_valid          in   if_instruction valid this cycle
//   reg_data1/2       in   [31:0] operands of the instruction being fetched
//   uc_pc             in   [15:0] microcode sequencer PC
//   set_catch         out  microcode sequencer enable (ARM, RUN)
//   orig_instruction  out  [31:0] captured MUL, held until next capture
//   stall_pc          out  freeze main PC / fetch (any non-IDLE state)
//   busy              out  controller not IDLE
//   flag_we           out  one-cycle flag write strobe (FLAGS)
//   flag_z, flag_n    out  flag values computed at capture
//   uc_fault          out  sticky sequencer timeout
//   trap_count        out  [15:0] completed traps, wraps
module mul_trap_ctrl
  import mul_trap_pkg::*;
#(
  parameter logic [15:0] UC_END_PC    = DEF_UC_END_PC,
  parameter int          TIMEOUT      = DEF_TIMEOUT,
  parameter int          DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_instruction,
  input  logic        if_valid,
  input  logic [31:0] reg_data1,
  input  logic [31:0] reg_data2,
  input  logic [15:0] uc_pc,
  output logic        set_catch,
  output logic [31:0] orig_instruction,
  output logic        stall_pc,
  output logic        busy,
  output logic        flag_we,
  output logic        flag_z,
  output logic        flag_n,
  output logic        uc_fault,
  output logic [15:0] trap_count
);

  // DRAIN_CYCLES is expected to be at least 1.
  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t        state;
  state_t        state_nxt;
  logic          set_flags;
  logic [DW-1:0] drain_cnt;
  logic          drain_last;

  logic [6:0]    op;
  logic          take;
  logic          cap_z;
  logic          cap_n;
  logic          cap_sf;

  logic          uc_done;
  logic          tmo_clear;
  logic          tmo_enable;
  logic          tmo_expired;

  // Capture-side decode: flags are computed from the operands presented
  // alongside the fetched instruction, since the register file moves on
  // once the pipeline is frozen.
  always_comb begin
    op     = if_instruction[31:25];
    take   = if_valid && is_mul_op(op);
    cap_sf = is_flag_form(op);
    if (is_imm_form(op)) begin
      cap_z = (reg_data1 == '0) || (if_instruction[15:0] == '0);
      cap_n = reg_data1[31] ^ if_instruction[15];
    end else begin
      cap_z = (reg_data1 == '0) || (reg_data2 == '0);
      cap_n = reg_data1[31] ^ reg_data2[31];
    end
  end

  assign uc_done    = (uc_pc == UC_END_PC);
  assign drain_last = (drain_cnt == DRAIN_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (take) state_nxt = ST_ARM;
      ST_ARM:   state_nxt = ST_RUN;
      // Completion is tested first so it wins over a coincident timeout.
      ST_RUN: begin
        if (uc_done) begin
          state_nxt = ST_DRAIN;
        end else if (tmo_expired) begin
          state_nxt = ST_FAULT;
        end
      end
      ST_DRAIN: if (drain_last) state_nxt = set_flags ? ST_FLAGS : ST_IDLE;
      ST_FLAGS: state_nxt = ST_IDLE;
      ST_FAULT: state_nxt = ST_FAULT;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The watchdog is zeroed during the single ARM cycle and only counts
  // while the sequencer is actually running.
  assign tmo_clear  = (state == ST_ARM);
  assign tmo_enable = (state == ST_RUN);

  trap_timeout_ctr #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= ST_IDLE;
      set_flags        <= 1'b0;
      orig_instruction <= '0;
      flag_z           <= 1'b0;
      flag_n           <= 1'b0;
      trap_count       <= '0;
      drain_cnt        <= '0;
    end else begin
      state <= state_nxt;

      if (state == ST_IDLE && take) begin
        orig_instruction <= if_instruction;
        flag_z           <= cap_z;
        flag_n           <= cap_n;
        set_flags        <= cap_sf;
      end

      if (state == ST_DRAIN) begin
        drain_cnt <= drain_cnt + DW'(1);
      end else begin
        drain_cnt <= '0;
      end

      if (state == ST_DRAIN && drain_last) begin
        trap_count <= trap_count + 16'd1;
      end
    end
  end

  assign set_catch = (state == ST_ARM) || (state == ST_RUN);
  assign busy      = (state != ST_IDLE);
  assign stall_pc  = busy;
  assign flag_we   = (state == ST_FLAGS);
  assign uc_fault  = (state == ST_FAULT);

endmodule

// File: tb/tb_mul_trap_ctrl.sv
// tb/tb_mul_trap_ctrl.sv - directed scoreboard bench for mul_trap_ctrl
module tb_mul_trap_ctrl;

  localparam logic [15:0] END_PC = 16'd124;
  localparam int          TMO    = 1024;
  localparam int          DRN    = 2;

  localparam logic [6:0] T_MULI  = 7'b0010000;
  localparam logic [6:0] T_MULSI = 7'b0011000;
  localparam logic [6:0] T_MUL   = 7'b0110000;
  localparam logic [6:0] T_MULS  = 7'b0111000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_instruction;
  logic        if_valid;
  logic [31:0] reg_data1;
  logic [31:0] reg_data2;
  logic [15:0] uc_pc;
  logic        set_catch;
  logic [31:0] orig_instruction;
  logic        stall_pc;
  logic        busy;
  logic        flag_we;
  logic        flag_z;
  logic        flag_n;
  logic        uc_fault;
  logic [15:0] trap_count;

  int total = 0;
  int bad   = 0;
  int n_traps = 0;

  typedef struct {
    logic [31:0] instr;
    logic        z;
    logic        n;
    int          we;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mul_trap_ctrl #(
    .UC_END_PC    (END_PC),
    .TIMEOUT      (TMO),
    .DRAIN_CYCLES (DRN)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_instruction   (if_instruction),
    .if_valid         (if_valid),
    .reg_data1        (reg_data1),
    .reg_data2        (reg_data2),
    .uc_pc            (uc_pc),
    .set_catch        (set_catch),
    .orig_instruction (orig_instruction),
    .stall_pc         (stall_pc),
    .busy             (busy),
    .flag_we          (flag_we),
    .flag_z           (flag_z),
    .flag_n           (flag_n),
    .uc_fault         (uc_fault),
    .trap_count       (trap_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected flags: the immediate operand is treated as a sign-extended
  // 32-bit value, and the product sign/zero derived from the two operands.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1,
                                 input logic [31:0] r2);
    exp_t        e;
    logic [6:0]  o;
    logic [31:0] b;
    o = ins[31:25];
    b = (o == T_MULI || o == T_MULSI) ? {{16{ins[15]}}, ins[15:0]} : r2;
    e.instr = ins;
    e.z     = (r1 == 32'd0) || (b == 32'd0);
    e.n     = r1[31] ^ b[31];
    e.we    = (o == T_MULS || o == T_MULSI) ? 1 : 0;
    return e;
  endfunction

  task automatic check_reset_vals(input string pre);
    chk({pre, ":set_catch"}, set_catch, 0);
    chk({pre, ":stall_pc"}, stall_pc, 0);
    chk({pre, ":busy"}, busy, 0);
    chk({pre, ":flag_we"}, flag_we, 0);
    chk({pre, ":flag_z"}, flag_z, 0);
    chk({pre, ":flag_n"}, flag_n, 0);
    chk({pre, ":uc_fault"}, uc_fault, 0);
    chk({pre, ":orig"}, orig_instruction, 0);
    chk({pre, ":trap_count"}, trap_count, 0);
  endtask

  // Drives one trap from capture to return to IDLE. uc_pc is raised to the
  // end PC during the catch_len-th set_catch cycle. With intrude set, a
  // second MUL is presented mid-RUN and must be ignored.
  task automatic run_trap(input string tag, input logic [31:0] ins, input logic [31:0] r1,
                          input logic [31:0] r2, input int catch_len, input bit intrude);
    exp_t e;
    int   c_cnt = 0;
    int   post = 0;
    int   we_cnt = 0;
    bit   done = 0;
    bit   seen_end = 0;
    logic wz = 1'b0;
    logic wn = 1'b0;

    sb.push_back(model(ins, r1, r2));
    if_instruction = ins;
    if_valid       = 1'b1;
    reg_data1      = r1;
    reg_data2      = r2;
    uc_pc          = 16'd0;

    for (int i = 0; i < catch_len + 50 && !done; i++) begin
      @(negedge clk);
      if_valid  = 1'b0;
      reg_data1 = $urandom;
      reg_data2 = $urandom;
      if (i == 0) chk({tag, ":stall_latency"}, stall_pc, 1);
      if (uc_pc == END_PC) begin
        uc_pc    = 16'd0;
        seen_end = 1;
      end
      if (!stall_pc) begin
        done = 1;
      end else begin
        if (set_catch) c_cnt++;
        if (seen_end) post++;
        if (flag_we) begin
          we_cnt++;
          wz = flag_z;
          wn = flag_n;
        end
        if (set_catch && c_cnt == catch_len) uc_pc = END_PC;
        if (intrude && c_cnt == 5) begin
          if_instruction = {T_MULS, 25'h0AAAAAA};
          if_valid       = 1'b1;
          reg_data1      = 32'd0;
          reg_data2      = 32'd0;
        end
      end
    end

    n_traps++;
    e = sb.pop_front();
    chk({tag, ":completed"}, {31'd0, done}, 1);
    chk({tag, ":catch_cycles"}, c_cnt, catch_len);
    chk({tag, ":post_stall"}, post, DRN + e.we);
    chk({tag, ":flag_we_pulses"}, we_cnt, e.we);
    if (e.we != 0) begin
      chk({tag, ":we_z"}, {31'd0, wz}, {31'd0, e.z});
      chk({tag, ":we_n"}, {31'd0, wn}, {31'd0, e.n});
    end
    chk({tag, ":orig"}, orig_instruction, e.instr);
    chk({tag, ":flag_z"}, flag_z, {31'd0, e.z});
    chk({tag, ":flag_n"}, flag_n, {31'd0, e.n});
    chk({tag, ":trap_count"}, trap_count, n_traps);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c_cnt;

    rst            = 1'b0;
    if_instruction = 32'd0;
    if_valid       = 1'b0;
    reg_data1      = 32'd0;
    reg_data2      = 32'd0;
    uc_pc          = 16'd0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;

    // Non-MUL opcode, then a MUL without if_valid: both ignored.
    if_instruction = {7'b1100100, 25'h0000001};
    if_valid       = 1'b1;
    @(negedge clk);
    chk("non_mul:busy", busy, 0);
    chk("non_mul:orig", orig_instruction, 0);
    if_instruction = {T_MUL, 25'h0000042};
    if_valid       = 1'b0;
    @(negedge clk);
    chk("no_valid:busy", busy, 0);
    chk("no_valid:orig", orig_instruction, 0);

    run_trap("mul_basic", {T_MUL, 25'h0012345}, 32'd5, 32'd3, 31, 1'b1);
    run_trap("mulsi_neg", {T_MULSI, 9'h011, 16'h0004}, 32'h80000000, 32'h12345678, 8, 1'b0);
    run_trap("muls_zero", {T_MULS, 25'h0004321}, 32'd7, 32'd0, 5, 1'b0);
    run_trap("muli_imm0", {T_MULI, 9'h1FF, 16'h0000}, 32'hFFFFFFFF, 32'd9, 4, 1'b0);
    run_trap("mulsi_negimm", {T_MULSI, 9'h000, 16'h8001}, 32'h00000003, 32'd0, 6, 1'b0);
    run_trap("muls_bothneg", {T_MULS, 25'h1F0F0F0}, 32'hFFFFFFFE, 32'h80000001, 3, 1'b0);
    run_trap("done_vs_tmo", {T_MUL, 25'h0000777}, 32'd11, 32'd13, TMO + 1, 1'b0);

    // Reset in the middle of RUN.
    if_instruction = {T_MUL, 25'h0000101};
    if_valid       = 1'b1;
    reg_data1      = 32'h80000000;
    reg_data2      = 32'd2;
    @(negedge clk);
    if_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("midrun:set_catch_before", set_catch, 1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrun_reset");
    rst     = 1'b1;
    n_traps = 0;
    run_trap("after_reset", {T_MUL, 25'h0000202}, 32'd9, 32'd2, 6, 1'b0);

    // Sequencer never completes: fault after TMO RUN cycles.
    if_instruction = {T_MUL, 25'h0000303};
    if_valid       = 1'b1;
    reg_data1      = 32'd1;
    reg_data2      = 32'd1;
    uc_pc          = 16'd8;
    c_cnt          = 0;
    for (int i = 0; i < TMO + 100; i++) begin
      @(negedge clk);
      if_valid = 1'b0;
      if (uc_fault) break;
      if (set_catch) c_cnt++;
    end
    chk("fault:raised", uc_fault, 1);
    chk("fault:catch_cycles", c_cnt, TMO + 1);
    repeat (5) @(negedge clk);
    chk("fault:sticky", uc_fault, 1);
    chk("fault:stall_pc", stall_pc, 1);
    chk("fault:busy", busy, 1);
    chk("fault:set_catch", set_catch, 0);
    chk("fault:trap_count", trap_count, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_reset_vals("fault_reset");
    @(negedge clk);
    chk("fault_reset:idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
